// File: rtl/apple1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apple1_pkg
//  Description : Shared definitions for the Apple-I text paste path: paste
//                sequencer state encoding, ASCII control codes and the PIA
//                keyboard "key available" bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package apple1_pkg;

    // Paste sequencer states (explicit 3-bit encoding).
    typedef logic [2:0] paste_state_t;
    localparam paste_state_t ST_IDLE     = 3'd0;
    localparam paste_state_t ST_LOAD     = 3'd1;
    localparam paste_state_t ST_GAP      = 3'd2;
    localparam paste_state_t ST_ISSUE    = 3'd3;
    localparam paste_state_t ST_WAIT_ACK = 3'd4;

    // ASCII control codes that receive special treatment during playback.
    localparam logic [7:0] ASC_NUL = 8'h00;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_CR  = 8'h0D;

    // The PIA keyboard port expects bit 7 set on every character.
    localparam logic [7:0] KBD_BIT7 = 8'h80;

    // Forms the byte presented to the PIA: the 7-bit code with bit 7 forced.
    function automatic logic [7:0] kbd_char(input logic [7:0] ch);
        return ch | KBD_BIT7;
    endfunction

endpackage : apple1_pkg
`default_nettype wire

// File: rtl/paste_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : paste_buffer
//  Description : Simple dual-port byte RAM holding the downloaded text file.
//                One write port, one read port with a synchronous read
//                (data valid the cycle after i_rd_en). The read register holds
//                its value while i_rd_en is low.
//  Ports       : clk        - clock
//                i_wr_en    - write enable
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_en    - read enable
//                i_rd_addr  - read address
//                o_rd_data  - read data (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module paste_buffer #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [7:0] r_mem [c_DEPTH];
    logic [7:0] r_rd_data;

    // No reset: contents are undefined until the first download.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : paste_buffer
`default_nettype wire

// File: rtl/text_paste_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : text_paste_sequencer
//  Description : Captures an ASCII file downloaded over ioctl into a local
//                buffer, then replays it into the Apple-I keyboard port one
//                character at a time. Each character waits for the CPU to read
//                the KBD register (kbd_ack) plus a programmable gap; a longer
//                gap follows CR so the monitor can finish the line. Live PS/2
//                keys share the port and take priority over pasted text.
//
//  Build option: define PASTE_CASEFOLD_EN to fold pasted lowercase letters
//                (0x61-0x7A) to uppercase; live keys are never folded.
//
//  Ports       : clk25          - system clock
//                reset          - asynchronous active-high reset
//                ioctl_download - text download active
//                ioctl_wr       - write strobe for ioctl_data
//                ioctl_addr     - byte address of ioctl_data
//                ioctl_data     - downloaded byte
//                ps2_strobe     - live key decoded (1-cycle pulse)
//                ps2_ascii      - live key ASCII
//                kbd_ack        - CPU read of the PIA KBD register (pulse)
//                kbd_strobe     - new character on kbd_data (1-cycle pulse)
//                kbd_data       - character to PIA, bit 7 always set
//                busy           - sequencer in LOAD/GAP/ISSUE/WAIT_ACK
//                overflow       - last download exceeded the buffer (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module text_paste_sequencer
    import apple1_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int CHAR_GAP = 25000,
    parameter int CR_GAP   = 500000
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ps2_strobe,
    input  logic [7:0]  ps2_ascii,
    input  logic        kbd_ack,
    output logic        kbd_strobe,
    output logic [7:0]  kbd_data,
    output logic        busy,
    output logic        overflow
);

    // Gap counter sized for the larger of the two gaps (at least 1 bit).
    localparam int c_GAP_MAX = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
    localparam int c_GAP_W   = $clog2(((c_GAP_MAX > 0) ? c_GAP_MAX : 1) + 1);
    localparam logic [c_GAP_W-1:0] c_CHAR_GAP = c_GAP_W'(CHAR_GAP);
    localparam logic [c_GAP_W-1:0] c_CR_GAP   = c_GAP_W'(CR_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ZERO = '0;
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    // Lengths and pointers carry one extra bit so a full buffer
    // (2**ADDR_W bytes) is representable.
    localparam logic [ADDR_W:0] c_PTR_ZERO = '0;
    localparam logic [ADDR_W:0] c_PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    paste_state_t        r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_rd_ptr;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_dl_q;       // ioctl_download delayed, for edges
    logic                r_last_cr;    // last issued pasted char was CR
    logic                r_overflow;
    logic                r_kbd_strobe;
    logic [7:0]          r_kbd_data;
    logic                r_live_pend;  // live key waiting out a strobe
    logic [7:0]          r_live_char;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_dl_rise;
    logic                w_dl_fall;
    logic                w_in_play;
    logic                w_abort_live;
    logic                w_live_req;
    logic                w_live_fire;
    logic [7:0]          w_live_char;
    logic                w_addr_ok;
    logic                w_wr_en;
    logic [ADDR_W:0]     w_wr_len;
    logic [ADDR_W:0]     w_rd_next;
    logic                w_last;
    logic                w_gap_zero;
    logic                w_rd_en;
    logic [7:0]          w_rd_data;
    logic                w_skip;
    logic [7:0]          w_xlat;
    logic                w_issue_ok;
    logic                w_paste_fire;

    assign w_dl_rise  = ioctl_download & ~r_dl_q;
    assign w_dl_fall  = ~ioctl_download & r_dl_q;
    assign w_in_play  = (r_state == ST_GAP) || (r_state == ST_ISSUE) ||
                        (r_state == ST_WAIT_ACK);

    // A live key during playback aborts it; a new download takes precedence.
    assign w_abort_live = ps2_strobe & w_in_play & ~w_dl_rise;

    // Live keys are strobed the cycle after they arrive. If a strobe is
    // already on the port, the key is held one more cycle so kbd_strobe is
    // never high on two consecutive cycles.
    assign w_live_req  = ps2_strobe | r_live_pend;
    assign w_live_fire = w_live_req & ~r_kbd_strobe;
    assign w_live_char = ps2_strobe ? ps2_ascii : r_live_char;

    // Only addresses inside the buffer are stored; the rest flag overflow.
    assign w_addr_ok = ((ioctl_addr >> ADDR_W) == 16'd0);
    assign w_wr_en   = (r_state == ST_LOAD) & ioctl_download & ioctl_wr & w_addr_ok;
    assign w_wr_len  = {1'b0, ioctl_addr[ADDR_W-1:0]} + c_PTR_ONE;

    assign w_rd_next  = r_rd_ptr + c_PTR_ONE;
    assign w_last     = (w_rd_next == r_len);
    assign w_gap_zero = (r_gap_cnt == c_GAP_ZERO);

    // The read is launched on the last GAP cycle so the byte is ready in ISSUE.
    assign w_rd_en = (r_state == ST_GAP) & w_gap_zero & ~w_dl_rise & ~ps2_strobe;

    paste_buffer #(
        .ADDR_W (ADDR_W)
    ) u_buffer (
        .clk       (clk25),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (ioctl_addr[ADDR_W-1:0]),
        .i_wr_data (ioctl_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    // Byte translation for playback: NUL is dropped, LF becomes CR unless it
    // completes a CRLF pair (then it is dropped).
    always_comb begin
        w_skip = 1'b0;
        w_xlat = w_rd_data;
        if (w_rd_data == ASC_NUL) begin
            w_skip = 1'b1;
        end else if (w_rd_data == ASC_LF) begin
            if (r_last_cr) begin
                w_skip = 1'b1;
            end else begin
                w_xlat = ASC_CR;
            end
        end
`ifdef PASTE_CASEFOLD_EN
        else if ((w_rd_data >= 8'h61) && (w_rd_data <= 8'h7A)) begin
            w_xlat = w_rd_data - 8'h20;
        end
`endif
    end

    // ISSUE proceeds only when nothing else owns the port this cycle; if a
    // previous strobe is still on the port it waits one cycle (the RAM
    // output register holds the byte meanwhile).
    assign w_issue_ok   = (r_state == ST_ISSUE) & ~w_dl_rise & ~ps2_strobe &
                          ~r_live_pend & ~r_kbd_strobe;
    assign w_paste_fire = w_issue_ok & ~w_skip;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_len      <= c_PTR_ZERO;
            r_rd_ptr   <= c_PTR_ZERO;
            r_gap_cnt  <= c_GAP_ZERO;
            r_dl_q     <= 1'b0;
            r_last_cr  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_dl_q <= ioctl_download;

            if (w_dl_rise && (r_state != ST_LOAD)) begin
                // New download: from IDLE or aborting any playback.
                r_state    <= ST_LOAD;
                r_len      <= c_PTR_ZERO;
                r_rd_ptr   <= c_PTR_ZERO;
                r_gap_cnt  <= c_GAP_ZERO;
                r_last_cr  <= 1'b0;
                r_overflow <= 1'b0;
            end else if (w_abort_live) begin
                // Live typing cancels the paste; the file stays loaded.
                r_state   <= ST_IDLE;
                r_rd_ptr  <= c_PTR_ZERO;
                r_gap_cnt <= c_GAP_ZERO;
                r_last_cr <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_dl_fall) begin
                            r_state   <= (r_len != c_PTR_ZERO) ? ST_GAP : ST_IDLE;
                            r_gap_cnt <= c_CHAR_GAP;
                        end else if (ioctl_download && ioctl_wr) begin
                            if (w_addr_ok) begin
                                if (w_wr_len > r_len) begin
                                    r_len <= w_wr_len;
                                end
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end

                    ST_GAP: begin
                        if (!w_gap_zero) begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end

                    ST_ISSUE: begin
                        if (w_issue_ok) begin
                            if (w_skip) begin
                                r_last_cr <= 1'b0;
                                r_rd_ptr  <= w_rd_next;
                                r_gap_cnt <= c_GAP_ZERO;
                                r_state   <= w_last ? ST_IDLE : ST_GAP;
                            end else begin
                                r_last_cr <= (w_xlat == ASC_CR);
                                r_state   <= ST_WAIT_ACK;
                            end
                        end
                    end

                    ST_WAIT_ACK: begin
                        if (kbd_ack) begin
                            r_rd_ptr <= w_rd_next;
                            if (w_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state   <= ST_GAP;
                                r_gap_cnt <= r_last_cr ? c_CR_GAP : c_CHAR_GAP;
                            end
                        end
                    end

                    default: begin
                        // IDLE: leaves only on a download rising edge (above).
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Keyboard port driver (live keys and pasted text are mutually exclusive)
    // ------------------------------------------------------------------
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            r_kbd_strobe <= 1'b0;
            r_kbd_data   <= KBD_BIT7;
            r_live_pend  <= 1'b0;
            r_live_char  <= 8'h00;
        end else begin
            r_live_pend  <= w_live_req & r_kbd_strobe;
            if (ps2_strobe) begin
                r_live_char <= ps2_ascii;
            end
            r_kbd_strobe <= w_live_fire | w_paste_fire;
            if (w_live_fire) begin
                r_kbd_data <= kbd_char(w_live_char);
            end else if (w_paste_fire) begin
                r_kbd_data <= kbd_char(w_xlat);
            end
        end
    end

    assign kbd_strobe = r_kbd_strobe;
    assign kbd_data   = r_kbd_data;
    assign busy       = (r_state != ST_IDLE);
    assign overflow   = r_overflow;

endmodule : text_paste_sequencer
`default_nettype wire

// File: tb/tb_text_paste_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_paste_sequencer
//  Description : Scoreboard bench for text_paste_sequencer. Stimulus pushes
//                the expected kbd_data bytes; a monitor pops and compares on
//                every kbd_strobe and checks strobe spacing. An ack responder
//                plays the role of the CPU reading the KBD register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_paste_sequencer;

    localparam int c_ADDR_W   = 13;
    localparam int c_CHAR_GAP = 2;
    localparam int c_CR_GAP   = 10;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'h0;
    logic [7:0]  ioctl_data = 8'h0;
    logic        ps2_strobe = 1'b0;
    logic [7:0]  ps2_ascii = 8'h0;
    logic        kbd_ack = 1'b0;
    logic        kbd_strobe;
    logic [7:0]  kbd_data;
    logic        busy;
    logic        overflow;

    text_paste_sequencer #(
        .ADDR_W   (c_ADDR_W),
        .CHAR_GAP (c_CHAR_GAP),
        .CR_GAP   (c_CR_GAP)
    ) dut (
        .clk25          (clk25),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ps2_strobe     (ps2_strobe),
        .ps2_ascii      (ps2_ascii),
        .kbd_ack        (kbd_ack),
        .kbd_strobe     (kbd_strobe),
        .kbd_data       (kbd_data),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk25 = ~clk25;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk25) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] dl_buf[$];
    int  strobe_cnt  = 0;
    int  ack_cyc     = 0;
    bit  ack_since   = 1'b0;
    bit  mon_last_cr = 1'b0;
    bit  prev_strobe = 1'b0;
    bit  auto_ack    = 1'b1;
    int  ack_budget  = 1 << 30;

    function automatic void check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor / scoreboard: sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk25);
            if (!reset) begin
                if (kbd_ack) begin
                    ack_cyc   = cyc;
                    ack_since = 1'b1;
                end
                if (kbd_strobe) begin
                    strobe_cnt++;
                    if (prev_strobe) begin
                        check("strobe_not_back_to_back", 1, 0);
                    end
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: got 0x%0h, expected no strobe", kbd_data);
                    end else begin
                        check("kbd_data", int'(kbd_data), int'(exp_q.pop_front()));
                    end
                    if (ack_since) begin
                        check("ack_to_strobe_gap_ok",
                              int'((cyc - ack_cyc) >= (mon_last_cr ? c_CR_GAP : c_CHAR_GAP)), 1);
                    end
                    ack_since   = 1'b0;
                    mon_last_cr = (kbd_data == 8'h8D);
                end
                prev_strobe = kbd_strobe;
            end
        end
    end

    // CPU model: reads the KBD register shortly after each strobe.
    initial begin
        forever begin
            @(negedge clk25);
            if (kbd_strobe && auto_ack && ack_budget > 0) begin
                ack_budget--;
                @(posedge clk25); #1 kbd_ack = 1'b1;
                @(posedge clk25); #1 kbd_ack = 1'b0;
            end
        end
    end

    // Watchdog.
    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic download();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < dl_buf.size(); i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 16'(i);
            ioctl_data = dl_buf[i];
            tick();
        end
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_busy_falls"}, int'(busy), 0);
        repeat (4) tick();
        check({name, "_all_expected_seen"}, exp_q.size(), 0);
    endtask

    task automatic wait_strobes(input string name, input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_strobe_reached"}, int'(strobe_cnt >= target), 1);
    endtask

    initial begin
        int s0;

        repeat (3) @(posedge clk25);
        #1 reset = 1'b0;
        tick();
        check("rst_kbd_strobe", int'(kbd_strobe), 0);
        check("rst_kbd_data",   int'(kbd_data),   8'h80);
        check("rst_busy",       int'(busy),       0);
        check("rst_overflow",   int'(overflow),   0);

        // "A\nB": LF becomes CR, longer gap after CR.
        s0 = strobe_cnt;
        exp_q  = '{8'hC1, 8'h8D, 8'hC2};
        dl_buf = '{8'h41, 8'h0A, 8'h42};
        download();
        check("t1_busy_during_load", int'(busy), 1);
        wait_idle("t1", 2000);
        check("t1_count", strobe_cnt - s0, 3);
        check("t1_overflow", int'(overflow), 0);

        // "X\r\n\0Y": CRLF collapses, NUL dropped.
        s0 = strobe_cnt;
        exp_q  = '{8'hD8, 8'h8D, 8'hD9};
        dl_buf = '{8'h58, 8'h0D, 8'h0A, 8'h00, 8'h59};
        download();
        wait_idle("t2", 2000);
        check("t2_count", strobe_cnt - s0, 3);

        // Lowercase handling.
        s0 = strobe_cnt;
`ifdef PASTE_CASEFOLD_EN
        exp_q = '{8'hC1, 8'hC2, 8'hC3};
`else
        exp_q = '{8'hE1, 8'hE2, 8'hE3};
`endif
        dl_buf = '{8'h61, 8'h62, 8'h63};
        download();
        wait_idle("t3", 2000);
        check("t3_count", strobe_cnt - s0, 3);

        // Live key during WAIT_ACK of the third char aborts the paste.
        s0 = strobe_cnt;
        ack_budget = 2;
        exp_q  = '{8'hC1, 8'hC2, 8'hC3};
        dl_buf = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        download();
        wait_strobes("t4", s0 + 3, 2000);
        exp_q.push_back(8'hD2);
        ps2_ascii  = 8'h52;
        ps2_strobe = 1'b1;
        tick();
        ps2_strobe = 1'b0;
        repeat (60) tick();
        check("t4_busy_after_live", int'(busy), 0);
        check("t4_all_expected_seen", exp_q.size(), 0);
        check("t4_count", strobe_cnt - s0, 4);
        ack_budget = 1 << 30;

        // New download started during GAP replaces the playback.
        s0 = strobe_cnt;
        auto_ack = 1'b0;
        exp_q  = '{8'hC1};
        dl_buf = '{8'h41, 8'h42, 8'h43};
        download();
        wait_strobes("t5", s0 + 1, 2000);
        kbd_ack = 1'b1;
        tick();
        kbd_ack = 1'b0;
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hD1);
        auto_ack = 1'b1;
        dl_buf = '{8'h50, 8'h51};
        download();
        wait_idle("t5", 2000);
        check("t5_count", strobe_cnt - s0, 3);

        // 8200-byte file: only 8192 fit, overflow flagged.
        s0 = strobe_cnt;
        dl_buf.delete();
        for (int i = 0; i < 8200; i++) begin
            dl_buf.push_back(8'h41 + 8'(i % 26));
            if (i < 8192) exp_q.push_back(8'hC1 + 8'(i % 26));
        end
        download();
        check("t6_overflow", int'(overflow), 1);
        wait_idle("t6", 70000);
        check("t6_count", strobe_cnt - s0, 8192);
        check("t6_overflow_sticky", int'(overflow), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_text_paste_sequencer
`default_nettype wire
